ftq_multi_commit: RTL and testbench
===================================

Name: ftq_multi_commit

Overview:
- Parametrised fetch-target queue (FTQ) between the BPU and fetch, and the successor to the fixed 64-entry BPU queue.
- Stores one predicted fetch block per entry: PC, type, GHR, RAS snapshot, packed by the BPU into ENTRY_W bits.
- Three pointers: enqueue (BPU writes), fetch (front-end reads), commit (ROB retires up to COMMIT_N entries per cycle).
- Supports full flush and partial redirect to a given entry.
- Exposes the oldest entry so the predictors can be updated.

Parameters:
DEPTH, 64, entry count; power of two, at least 4.
PTR_W, 6, log2(DEPTH); pointers are PTR_W+1 bits internally, the MSB being the wrap bit.
ENTRY_W, 261, payload width per entry.
COMMIT_N, 4, maximum entries retired per cycle.
CNT_W, 3, width of CommitNum; must hold COMMIT_N.

Ports:
Clk  in  1  clock.
Rest  in  1  synchronous, active-high reset.
FullFlush  in  1  discard all uncommitted entries.
RedirectValid  in  1  mispredict inside entry RedirectPtr; keep entries up to and including it.
RedirectPtr  in  PTR_W  index of the mispredicted entry.
FetchStop  in  1  stall toward fetch.
EnqValid  in  1  BPU offers an entry.
EnqData  in  ENTRY_W  entry payload.
EnqReady  out  1  queue can accept an entry.
EnqPtr  out  PTR_W  slot the next accepted entry is written to.
DeqValid  out  1  entry available to fetch.
DeqData  out  ENTRY_W  entry at the fetch pointer.
DeqPtr  out  PTR_W  fetch-pointer index, carried with the instructions.
DeqReady  in  1  fetch consumes the entry.
CommitNum  in  CNT_W  entries retired this cycle, 0..COMMIT_N.
HeadValid  out  1  queue non-empty.
HeadData  out  ENTRY_W  oldest entry, used for predictor update.
Count  out  PTR_W+1  occupancy, 0..DEPTH.
Full  out  1  Count == DEPTH.
Empty  out  1  Count == 0.
Err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - all pointers 0; Count 0; Empty 1; Full 0; EnqReady 1.
  - DeqValid 0; HeadValid 0; Err 0.
  - storage array not reset; DeqData and HeadData are don't-care while their valid is 0.
- Occupancy:
  - Count = wptr - cptr (PTR_W+1-bit subtraction).
  - Full = low bits equal and wrap bits differ.
  - Empty = pointers fully equal.
- Output timing:
  - EnqReady = !Full, computed from registered state only; a commit in the same cycle does not free space for that cycle's enqueue.
  - DeqValid = (fptr != wptr) && !FetchStop; DeqData/DeqPtr are a combinational read at fptr (show-ahead).
  - HeadValid = !Empty; HeadData is a combinational read at cptr.
- Enqueue: when EnqValid && EnqReady, write EnqData at wptr and increment wptr; the entry is visible on DeqValid the next cycle (1-cycle latency).
- Dequeue: when DeqValid && DeqReady, increment fptr.
- Commit:
  - Avail = fptr - cptr (fetched but not retired).
  - If CommitNum <= Avail, cptr += CommitNum.
  - Otherwise cptr += Avail and Err is set.
  - Commit is applied every cycle, including flush and redirect cycles.
- Priority, highest first: Rest > FullFlush > RedirectValid > normal enqueue/dequeue.
- FullFlush: wptr and fptr both take the post-commit cptr; same-cycle enqueue and dequeue are dropped; Count then equals 0.
- Redirect:
  - Legal only when RedirectPtr lies in [cptr, wptr) in wrap-aware order.
  - If legal, wptr and fptr both take RedirectPtr+1 with the correct wrap bit.
  - If illegal, the redirect is ignored, Err is set, and normal operation proceeds.
  - Same-cycle enqueue and dequeue are dropped on a legal redirect.
  - If the post-commit cptr has passed RedirectPtr+1, the pointers clamp to cptr.
- Wrap-around: the index wraps at DEPTH while the wrap bit toggles, so DEPTH entries are usable (no sacrificed slot).
- Full: EnqValid is held without loss; the entry enqueues in the first cycle EnqReady is 1.
- Reset mid-operation: all state returns to reset values in the next cycle regardless of other inputs.
- Err clears only on Rest.

Test Plan:
1. Enqueue 3 entries (A, B, C) with DeqReady=0 -> EnqPtr steps 0,1,2,3; Count=3; DeqData=A; HeadData=A; Empty=0.
2. Fill 64 entries, then hold EnqValid with CommitNum=2 while fetched entries are available -> Full=1 and EnqReady=0 in the commit cycle; next cycle Count=62, EnqReady=1, and the held entry enqueues at index 0 (wrap).
3. 10 entries written, 6 fetched, CommitNum=4 -> Count=6, HeadData=entry 4, DeqPtr=6; then CommitNum=4 again (Avail=2) -> cptr advances only 2, Err=1.
4. 10 written, 8 fetched, cptr=2, RedirectValid with RedirectPtr=5 -> next cycle wptr=fptr=6, Count=4, DeqValid=0; then RedirectPtr=9 (beyond wptr) -> ignored, Err=1.
5. FullFlush with CommitNum=1 and EnqValid=1 in the same cycle -> cptr+1, wptr=fptr=cptr, Count=0, Empty=1, enqueue dropped.
6. FetchStop=1 while non-empty -> DeqValid=0 and fptr unchanged; assert Rest mid-fill -> next cycle Count=0, EnqReady=1, Err=0.

Source files
------------

// File: rtl/ftq_multi_commit.sv
// Fetch-target queue between the BPU and fetch, retiring up to COMMIT_N entries per cycle.
// Latency: an enqueued entry is visible to fetch next cycle. Backpressure: EnqReady = !Full, from registered state only.
module ftq_multi_commit #(
  parameter int DEPTH    = 64,
  parameter int PTR_W    = 6,
  parameter int ENTRY_W  = 261,
  parameter int COMMIT_N = 4,
  parameter int CNT_W    = 3
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               FullFlush,
  input  logic               RedirectValid,
  input  logic [PTR_W-1:0]   RedirectPtr,
  input  logic               FetchStop,
  input  logic               EnqValid,
  input  logic [ENTRY_W-1:0] EnqData,
  output logic               EnqReady,
  output logic [PTR_W-1:0]   EnqPtr,
  output logic               DeqValid,
  output logic [ENTRY_W-1:0] DeqData,
  output logic [PTR_W-1:0]   DeqPtr,
  input  logic               DeqReady,
  input  logic [CNT_W-1:0]   CommitNum,
  output logic               HeadValid,
  output logic [ENTRY_W-1:0] HeadData,
  output logic [PTR_W:0]     Count,
  output logic               Full,
  output logic               Empty,
  output logic               Err
);

  localparam int PW = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W:0]     wptr, fptr, cptr;
  logic               err_q;

  logic [PTR_W:0]     avail, adv, cptr_nxt;
  logic               commit_over;
  logic [PTR_W-1:0]   rdist;
  logic [PTR_W:0]     rdist_inc, redir_ptr;
  logic               redir_legal, redir_take, redir_bad;
  logic               enq_fire, deq_fire;

  assign Count     = wptr - cptr;
  assign Full      = (wptr[PTR_W-1:0] == cptr[PTR_W-1:0]) && (wptr[PTR_W] != cptr[PTR_W]);
  assign Empty     = (wptr == cptr);
  assign EnqReady  = !Full;
  assign EnqPtr    = wptr[PTR_W-1:0];
  assign DeqValid  = (fptr != wptr) && !FetchStop;
  assign DeqPtr    = fptr[PTR_W-1:0];
  assign DeqData   = mem[fptr[PTR_W-1:0]];
  assign HeadValid = !Empty;
  assign HeadData  = mem[cptr[PTR_W-1:0]];
  assign Err       = err_q;

  // Retire no further than the fetch pointer; asking for more is a protocol error.
  assign avail       = fptr - cptr;
  assign commit_over = {{CNT_W{1'b0}}, avail} < {{PW{1'b0}}, CommitNum};
  assign adv         = commit_over ? avail : PW'(CommitNum);
  assign cptr_nxt    = cptr + adv;

  // Redirect distance from the head decides legality: it must name a live entry.
  assign rdist       = RedirectPtr - cptr[PTR_W-1:0];
  assign rdist_inc   = {1'b0, rdist} + PW'(1);
  assign redir_legal = {1'b0, rdist} < Count;
  assign redir_take  = RedirectValid && !FullFlush && redir_legal;
  assign redir_bad   = RedirectValid && !FullFlush && !redir_legal;
  assign redir_ptr   = (adv > rdist_inc) ? cptr_nxt : (cptr + rdist_inc);

  assign enq_fire = EnqValid && EnqReady && !FullFlush && !redir_take;
  assign deq_fire = DeqValid && DeqReady && !FullFlush && !redir_take;

  always_ff @(posedge Clk) begin
    if (Rest) begin
      wptr  <= '0;
      fptr  <= '0;
      cptr  <= '0;
      err_q <= 1'b0;
    end else begin
      cptr <= cptr_nxt;
      if (FullFlush) begin
        wptr <= cptr_nxt;
        fptr <= cptr_nxt;
      end else if (redir_take) begin
        wptr <= redir_ptr;
        fptr <= redir_ptr;
      end else begin
        if (enq_fire) wptr <= wptr + PW'(1);
        if (deq_fire) fptr <= fptr + PW'(1);
      end
      if (commit_over || redir_bad) err_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (enq_fire && !Rest) mem[wptr[PTR_W-1:0]] <= EnqData;
  end

endmodule

// File: tb/tb_ftq_multi_commit.sv
// Randomized and directed bench for ftq_multi_commit against an absolute-position queue model.
module tb_ftq_multi_commit;
  localparam int DEPTH = 64, PTR_W = 6, ENTRY_W = 261, COMMIT_N = 4, CNT_W = 3;

  logic               Clk = 1'b0;
  logic               Rest = 1'b1, FullFlush = 1'b0, RedirectValid = 1'b0, FetchStop = 1'b0;
  logic [PTR_W-1:0]   RedirectPtr = '0;
  logic               EnqValid = 1'b0, DeqReady = 1'b0;
  logic [ENTRY_W-1:0] EnqData = '0;
  logic [CNT_W-1:0]   CommitNum = '0;
  logic               EnqReady, DeqValid, HeadValid, Full, Empty, Err;
  logic [PTR_W-1:0]   EnqPtr, DeqPtr;
  logic [ENTRY_W-1:0] DeqData, HeadData;
  logic [PTR_W:0]     Count;

  always #5 Clk = ~Clk;

  ftq_multi_commit #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ENTRY_W(ENTRY_W), .COMMIT_N(COMMIT_N), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rest(Rest), .FullFlush(FullFlush), .RedirectValid(RedirectValid), .RedirectPtr(RedirectPtr),
    .FetchStop(FetchStop), .EnqValid(EnqValid), .EnqData(EnqData), .EnqReady(EnqReady), .EnqPtr(EnqPtr),
    .DeqValid(DeqValid), .DeqData(DeqData), .DeqPtr(DeqPtr), .DeqReady(DeqReady), .CommitNum(CommitNum),
    .HeadValid(HeadValid), .HeadData(HeadData), .Count(Count), .Full(Full), .Empty(Empty), .Err(Err)
  );

  int checks = 0, errors = 0;

  // Model: absolute (never wrapping) positions of write, fetch and commit.
  int mw = 0, mf = 0, mc = 0;
  bit merr = 1'b0;
  logic [ENTRY_W-1:0] mdata [DEPTH];
  logic [ENTRY_W-1:0] ent [16];

  task automatic chk(input string tag, input logic [ENTRY_W-1:0] got, input logic [ENTRY_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] rnd_entry();
    logic [ENTRY_W-1:0] d;
    for (int i = 0; i < ENTRY_W; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // Apply inputs at the falling edge, then compare every output against the model.
  task automatic drive(input int en, input int deq, input int cn, input int ff,
                       input int rv, input int rp, input int fs, input int rst);
    int cnt;
    @(negedge Clk);
    EnqValid = 1'(en); EnqData = rnd_entry(); DeqReady = 1'(deq); CommitNum = CNT_W'(cn);
    FullFlush = 1'(ff); RedirectValid = 1'(rv); RedirectPtr = PTR_W'(rp); FetchStop = 1'(fs); Rest = 1'(rst);
    #1;
    cnt = mw - mc;
    chk("count", ENTRY_W'(Count), ENTRY_W'(cnt));
    chk("full", ENTRY_W'(Full), ENTRY_W'(cnt == DEPTH));
    chk("empty", ENTRY_W'(Empty), ENTRY_W'(cnt == 0));
    chk("enq_rdy", ENTRY_W'(EnqReady), ENTRY_W'(cnt != DEPTH));
    chk("enq_ptr", ENTRY_W'(EnqPtr), ENTRY_W'(mw % DEPTH));
    chk("deq_vld", ENTRY_W'(DeqValid), ENTRY_W'((mf != mw) && (fs == 0)));
    chk("head_vld", ENTRY_W'(HeadValid), ENTRY_W'(cnt != 0));
    chk("err", ENTRY_W'(Err), ENTRY_W'(merr));
    if (mf != mw) begin
      chk("deq_ptr", ENTRY_W'(DeqPtr), ENTRY_W'(mf % DEPTH));
      chk("deq_dat", DeqData, mdata[mf % DEPTH]);
    end
    if (cnt != 0) chk("head_dat", HeadData, mdata[mc % DEPTH]);
  endtask

  // Advance the model by the rules for one clock, then let the clock edge happen.
  task automatic tick();
    int avail, cn, nc, k, t;
    bit redir, enq_ok, deq_ok;
    if (Rest) begin
      mw = 0; mf = 0; mc = 0; merr = 1'b0;
    end else begin
      avail = mf - mc;
      cn = int'(CommitNum);
      if (cn > avail) begin
        merr = 1'b1;
        nc = mc + avail;
      end else nc = mc + cn;
      enq_ok = EnqValid && ((mw - mc) != DEPTH);
      deq_ok = DeqReady && !FetchStop && (mf != mw);
      redir = 1'b0;
      if (FullFlush) begin
        mw = nc; mf = nc; redir = 1'b1;
      end else if (RedirectValid) begin
        k = mc + ((int'(RedirectPtr) - (mc % DEPTH) + DEPTH) % DEPTH);
        if (k < mw) begin
          t = (nc > k + 1) ? nc : k + 1;
          mw = t; mf = t; redir = 1'b1;
        end else merr = 1'b1;
      end
      if (!redir) begin
        if (enq_ok) begin
          mdata[mw % DEPTH] = EnqData;
          mw++;
        end
        if (deq_ok) mf++;
      end
      mc = nc;
    end
    @(posedge Clk);
  endtask

  task automatic cyc(input int en, input int deq, input int cn, input int ff,
                     input int rv, input int rp, input int fs, input int rst);
    drive(en, deq, cn, ff, rv, rp, fs, rst);
    tick();
  endtask

  initial begin
    int cnt, rp;
    @(posedge Clk);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // Three entries, no fetch.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      ent[i] = EnqData;
      chk("p1_enq_ptr", ENTRY_W'(EnqPtr), ENTRY_W'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p1_count", ENTRY_W'(Count), ENTRY_W'(3));
    chk("p1_deq_a", DeqData, ent[0]);
    chk("p1_head_a", HeadData, ent[0]);
    tick();

    // Fill to DEPTH, then commit frees space only for the following cycle.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 2, 0, 0, 0, 0, 0);
    chk("p2_full", ENTRY_W'(Full), ENTRY_W'(1));
    chk("p2_enq_rdy0", ENTRY_W'(EnqReady), ENTRY_W'(0));
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("p2_count62", ENTRY_W'(Count), ENTRY_W'(62));
    chk("p2_enq_rdy1", ENTRY_W'(EnqReady), ENTRY_W'(1));
    chk("p2_wrap_ptr", ENTRY_W'(EnqPtr), ENTRY_W'(0));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p2_count63", ENTRY_W'(Count), ENTRY_W'(63));
    tick();

    // Commit limited by fetched entries.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      ent[i] = EnqData;
      tick();
    end
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 4, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p3_count", ENTRY_W'(Count), ENTRY_W'(6));
    chk("p3_head4", HeadData, ent[4]);
    chk("p3_deq_ptr", ENTRY_W'(DeqPtr), ENTRY_W'(6));
    tick();
    cyc(0, 0, 4, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p3_err", ENTRY_W'(Err), ENTRY_W'(1));
    chk("p3_count4", ENTRY_W'(Count), ENTRY_W'(4));
    tick();

    // Legal then illegal redirect.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p4_count", ENTRY_W'(Count), ENTRY_W'(4));
    chk("p4_wptr", ENTRY_W'(EnqPtr), ENTRY_W'(6));
    chk("p4_fptr", ENTRY_W'(DeqPtr), ENTRY_W'(6));
    chk("p4_deq_vld", ENTRY_W'(DeqValid), ENTRY_W'(0));
    chk("p4_err0", ENTRY_W'(Err), ENTRY_W'(0));
    tick();
    cyc(0, 0, 0, 0, 1, 9, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p4_err1", ENTRY_W'(Err), ENTRY_W'(1));
    tick();

    // Flush with a same-cycle commit and enqueue.
    cyc(1, 0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p5_count", ENTRY_W'(Count), ENTRY_W'(0));
    chk("p5_empty", ENTRY_W'(Empty), ENTRY_W'(1));
    chk("p5_wptr", ENTRY_W'(EnqPtr), ENTRY_W'(3));
    tick();

    // Fetch stall, then reset mid-fill.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 0);
    chk("p6_stall", ENTRY_W'(DeqValid), ENTRY_W'(0));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p6_fptr", ENTRY_W'(DeqPtr), ENTRY_W'(3));
    tick();
    cyc(1, 1, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p6_count", ENTRY_W'(Count), ENTRY_W'(0));
    chk("p6_enq_rdy", ENTRY_W'(EnqReady), ENTRY_W'(1));
    chk("p6_err", ENTRY_W'(Err), ENTRY_W'(0));
    tick();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      cnt = mw - mc;
      if ($urandom_range(0, 9) < 7) rp = (mc + int'($urandom_range(0, (cnt > 0) ? cnt - 1 : 0))) % DEPTH;
      else rp = int'($urandom_range(0, DEPTH - 1));
      cyc(($urandom_range(0, 9) < 7) ? 1 : 0,
          ($urandom_range(0, 9) < 6) ? 1 : 0,
          int'($urandom_range(0, COMMIT_N)) * (($urandom_range(0, 3) == 0) ? 1 : 0),
          ($urandom_range(0, 99) < 2) ? 1 : 0,
          ($urandom_range(0, 99) < 5) ? 1 : 0,
          rp,
          ($urandom_range(0, 9) == 0) ? 1 : 0,
          ($urandom_range(0, 299) == 0) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
